// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit.
// Holds the RV32I load/store funct3 codes, the FSM state encoding, default
// sizes and the request classification helper used at accept time.
package dmem_pkg;

  localparam int DMEM_XLEN  = 32;
  localparam int DMEM_WORDS = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  // Returns 1 when the request must be rejected without touching memory:
  // funct3 not legal for the direction, misaligned half/word, or word index
  // beyond the implemented memory.
  function automatic logic access_err(input logic        we,
                                      input logic [2:0]  funct3,
                                      input logic [31:0] addr,
                                      input logic [31:0] mem_words);
    logic        legal;
    logic        misaligned;
    logic [31:0] widx;
    legal      = 1'b0;
    misaligned = 1'b0;
    widx       = {2'b00, addr[31:2]};
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = ~we;
      default:          legal = 1'b0;
    endcase
    case (funct3)
      F3_H, F3_HU: misaligned = addr[0];
      F3_W:        misaligned = (addr[1:0] != 2'b00);
      default:     misaligned = 1'b0;
    endcase
    return (~legal) | misaligned | (widx >= mem_words);
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response channel between the execute stage and the LSU.
// master: execute stage (drives req_*, receives req_ready and rsp_*)
// slave : load/store unit (receives req_*, drives req_ready and rsp_*)
interface dmem_lsu_if
  import dmem_pkg::*;
#(
  parameter int XLEN = DMEM_XLEN
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte/halfword lane handling for a word-only memory.
// Ports:
//   word       in  memory word just read
//   wdata      in  store data (low byte/half used for SB/SH)
//   funct3     in  RV32I load/store funct3
//   offset     in  byte offset addr[1:0]
//   load_data  out selected lane, sign- or zero-extended
//   store_word out word with the store lane merged in (SW: wdata)
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the byte addressed by the offset.
  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = 8'h00;
    endcase
  end

  // Halfword lane is chosen by offset[1] alone; offset[0] is already known 0.
  always_comb begin
    half_sel = 16'h0000;
    if (offset[1]) begin
      half_sel = word[31:16];
    end else begin
      half_sel = word[15:0];
    end
  end

  // Extend the selected lane to 32 bits.
  always_comb begin
    load_data = 32'h0000_0000;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'h00_0000, byte_sel};
      F3_HU:   load_data = {16'h0000, half_sel};
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Merge store data into the old word, keeping the untouched lanes.
  always_comb begin
    store_word = word;
    case (funct3)
      F3_B: begin
        case (offset)
          2'd0:    store_word = {word[31:8], wdata[7:0]};
          2'd1:    store_word = {word[31:16], wdata[7:0], word[7:0]};
          2'd2:    store_word = {word[31:24], wdata[7:0], word[15:0]};
          2'd3:    store_word = {wdata[7:0], word[23:0]};
          default: store_word = word;
        endcase
      end
      F3_H: begin
        if (offset[1]) begin
          store_word = {wdata[15:0], word[15:0]};
        end else begin
          store_word = {word[31:16], wdata[15:0]};
        end
      end
      F3_W:    store_word = wdata;
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator between the RV32I execute stage and a word-only,
// synchronous data memory. One request at a time; sub-word stores are done
// as read-modify-write because the memory has no byte enables.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   bus           request/response channel (slave side)
//   mem_address   word index of the latched byte address
//   mem_data_in   word to write
//   mem_we        write enable, high only in WR
//   mem_data_out  read word, valid the cycle after the read is issued
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS = DMEM_WORDS,
  parameter int XLEN      = DMEM_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  dmem_lsu_if.slave       bus,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_data_in,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_data_out
);

  state_t          state;
  state_t          next_state;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      funct3_q;
  logic            we_q;
  logic [XLEN-1:0] merged;
  logic            req_err;
  logic [XLEN-1:0] load_word;
  logic [XLEN-1:0] store_word;

  assign req_err       = access_err(bus.req_we, bus.req_funct3, bus.req_addr, 32'(MEM_WORDS));
  assign bus.req_ready = (state == IDLE);
  assign mem_address   = {2'b00, addr_q[XLEN-1:2]};
  assign mem_we        = (state == WR);

  dmem_lane_align u_align (
    .word       (mem_data_out),
    .wdata      (wdata_q),
    .funct3     (funct3_q),
    .offset     (addr_q[1:0]),
    .load_data  (load_word),
    .store_word (store_word)
  );

  // Write data: a full-word store writes the latched data directly, sub-word
  // stores write the word merged during CAP.
  always_comb begin
    mem_data_in = merged;
    if (funct3_q == F3_W) begin
      mem_data_in = wdata_q;
    end else begin
      mem_data_in = merged;
    end
  end

  // Next-state logic. Errors skip memory entirely; SW needs no read.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err) begin
            next_state = RESP;
          end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
            next_state = WR;
          end else begin
            next_state = RD;
          end
        end else begin
          next_state = IDLE;
        end
      end
      RD:  next_state = CAP;
      CAP: begin
        if (we_q) begin
          next_state = WR;
        end else begin
          next_state = RESP;
        end
      end
      WR:      next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, latched request, merged word and registered response.
  // rsp_* are loaded on the edge entering RESP so they are high only there.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      addr_q        <= {XLEN{1'b0}};
      wdata_q       <= {XLEN{1'b0}};
      funct3_q      <= 3'b000;
      we_q          <= 1'b0;
      merged        <= {XLEN{1'b0}};
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= {XLEN{1'b0}};
    end else begin
      state <= next_state;
      if ((state == IDLE) && bus.req_valid) begin
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        funct3_q <= bus.req_funct3;
        we_q     <= bus.req_we;
      end
      if ((state == CAP) && we_q) begin
        merged <= store_word;
      end
      bus.rsp_valid <= (next_state == RESP);
      bus.rsp_err   <= (state == IDLE) && (next_state == RESP);
      if ((state == CAP) && !we_q) begin
        bus.rsp_rdata <= load_word;
      end else begin
        bus.rsp_rdata <= {XLEN{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: behavioural memory + response model
// compared every cycle, plus directed requests with literal expectations.
module tb_dmem_lsu;
  import dmem_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_we;
  logic [31:0] mem_data_out;

  dmem_lsu_if bus ();

  dmem_lsu dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_we       (mem_we),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous word memory; preload port used only while the DUT is in reset.
  logic [31:0] ram [32];
  logic        preload_en;
  logic [4:0]  preload_idx;
  logic [31:0] preload_val;

  always @(posedge clk) begin
    if (preload_en) begin
      ram[preload_idx] <= preload_val;
    end else if (mem_we) begin
      if (mem_address < 32'd32) ram[mem_address[4:0]] <= mem_data_in;
    end else begin
      if (mem_address < 32'd32) mem_data_out <= ram[mem_address[4:0]];
    end
  end

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { int due; int idx; logic [31:0] data; } wr_t;
  rsp_t        rq[$];
  wr_t         wq[$];
  logic [31:0] ref_mem [32];
  int          cyc = 0;
  logic        chk_on = 1'b0;
  int          wr_cnt = 0;
  int          rsp_cnt = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;

  // Model of one accepted request, evaluated in the cycle before the accept edge.
  task automatic model_accept(input int c);
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a, w, v, r, mask, nw;
    int          widx, sh, lat;
    logic        legal, err;
    rsp_t        rs;
    wr_t         ws;
    we = bus.req_we; f3 = bus.req_funct3; a = bus.req_addr;
    widx = int'(a >> 2);
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    err = !legal || (f3[1:0] == 2'd1 && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0) || (a >= 32'd128);
    sh = 8 * int'(a[1:0]);
    r = 32'h0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat = 3;
      w = ref_mem[widx];
      v = w >> sh;
      case (f3)
        3'd0: r = 32'($signed(v[7:0]));
        3'd1: r = 32'($signed(v[15:0]));
        3'd4: r = v & 32'hFF;
        3'd5: r = v & 32'hFFFF;
        default: r = w;
      endcase
    end else begin
      lat = (f3 == 3'd2) ? 2 : 4;
      mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      mask = mask << sh;
      nw = (ref_mem[widx] & ~mask) | ((bus.req_wdata << sh) & mask);
      ws.due = c + lat - 1; ws.idx = widx; ws.data = nw;
      wq.push_back(ws);
    end
    rs.due = c + lat; rs.rdata = r; rs.err = err;
    rq.push_back(rs);
  endtask

  // Per-cycle compare against the model (outputs sampled on the falling edge).
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (preload_en) ref_mem[preload_idx] = preload_val;
      if (chk_on) begin
        check("req_ready", 32'(bus.req_ready), 32'(rq.size() == 0));
        check("mem_we", 32'(mem_we), 32'(wq.size() > 0 && wq[0].due == cyc));
        if (wq.size() > 0 && wq[0].due == cyc) begin
          check("mem_address", mem_address, 32'(wq[0].idx));
          check("mem_data_in", mem_data_in, wq[0].data);
          ref_mem[wq[0].idx] = wq[0].data;
          void'(wq.pop_front());
        end
        check("rsp_valid", 32'(bus.rsp_valid), 32'(rq.size() > 0 && rq[0].due == cyc));
        if (rq.size() > 0 && rq[0].due == cyc) begin
          check("rsp_rdata", bus.rsp_rdata, rq[0].rdata);
          check("rsp_err", 32'(bus.rsp_err), 32'(rq[0].err));
          void'(rq.pop_front());
        end
        if (bus.rsp_valid) rsp_cnt++;
        if (mem_we) begin
          wr_cnt++;
          last_wr_addr = mem_address;
          last_wr_data = mem_data_in;
        end
        if (reset) begin
          rq.delete();
          wq.delete();
        end else if (bus.req_valid && bus.req_ready) begin
          model_accept(cyc);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                        input int exp_wr, input logic [31:0] exp_wr_addr, input logic [31:0] exp_wr_data);
    int   wr0, lat;
    logic rdy, got;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    wr0 = wr_cnt;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); rdy = bus.req_ready;
      @(posedge clk); #1;
      if (rdy) begin got = 1'b1; break; end
    end
    bus.req_valid = 1'b0;
    if (!got) check({tag, ".accept_timeout"}, 32'd0, 32'd1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin lat = i; break; end
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".rdata"}, bus.rsp_rdata, exp_rdata);
    check({tag, ".err"}, 32'(bus.rsp_err), 32'(exp_err));
    check({tag, ".writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    if (exp_wr > 0) begin
      check({tag, ".wr_addr"}, last_wr_addr, exp_wr_addr);
      check({tag, ".wr_data"}, last_wr_data, exp_wr_data);
    end
  endtask

  initial begin
    int wr0, rsp0, acc;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    preload_en = 1'b0; preload_idx = 5'd0; preload_val = 32'h0;
    repeat (2) @(posedge clk);
    #1 chk_on = 1'b1;
    @(negedge clk);
    check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst.rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst.mem_address", mem_address, 32'd0);
    check("rst.mem_data_in", mem_data_in, 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.req_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      preload_en = 1'b1; preload_idx = 5'(i);
      preload_val = (i == 5) ? 32'h8070_F0A5 : (i == 3) ? 32'h1122_3344 : (32'hA5A5_0000 | 32'(i));
    end
    @(posedge clk); #1;
    preload_en = 1'b0;
    reset = 1'b0;

    do_req("lb14",  1'b0, F3_B,  32'h14, 32'h0, 32'hFFFF_FFA5, 1'b0, 3, 0, 32'h0, 32'h0);
    do_req("lbu15", 1'b0, F3_BU, 32'h15, 32'h0, 32'h0000_00F0, 1'b0, 3, 0, 32'h0, 32'h0);
    do_req("lh16",  1'b0, F3_H,  32'h16, 32'h0, 32'hFFFF_8070, 1'b0, 3, 0, 32'h0, 32'h0);
    do_req("lhu16", 1'b0, F3_HU, 32'h16, 32'h0, 32'h0000_8070, 1'b0, 3, 0, 32'h0, 32'h0);
    do_req("lw14",  1'b0, F3_W,  32'h14, 32'h0, 32'h8070_F0A5, 1'b0, 3, 0, 32'h0, 32'h0);
    do_req("sw08",  1'b1, F3_W,  32'h08, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1, 32'd2, 32'hDEAD_BEEF);
    do_req("lw08",  1'b0, F3_W,  32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 0, 32'h0, 32'h0);
    do_req("sb0d",  1'b1, F3_B,  32'h0D, 32'h0000_00AB, 32'h0, 1'b0, 4, 1, 32'd3, 32'h1122_AB44);
    do_req("sh0e",  1'b1, F3_H,  32'h0E, 32'h0000_CAFE, 32'h0, 1'b0, 4, 1, 32'd3, 32'hCAFE_AB44);
    do_req("lw0c",  1'b0, F3_W,  32'h0C, 32'h0, 32'hCAFE_AB44, 1'b0, 3, 0, 32'h0, 32'h0);
    do_req("lb0f",  1'b0, F3_B,  32'h0F, 32'h0, 32'hFFFF_FFCA, 1'b0, 3, 0, 32'h0, 32'h0);
    do_req("e_lw02", 1'b0, F3_W, 32'h02, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
    do_req("e_lh01", 1'b0, F3_H, 32'h01, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
    do_req("e_lw80", 1'b0, F3_W, 32'h80, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
    do_req("e_st4",  1'b1, F3_BU, 32'h10, 32'h1234_5678, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);

    // Reset while an SB sits in CAP: the write must be abandoned.
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_B;
    bus.req_addr = 32'h0C; bus.req_wdata = 32'h0000_0077;
    wr0 = wr_cnt;
    @(posedge clk); #1;          // RD
    bus.req_valid = 1'b0;
    @(posedge clk); #1;          // CAP
    reset = 1'b1;
    @(posedge clk); #1;          // back in IDLE
    reset = 1'b0;
    @(negedge clk);
    check("rst_cap.req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_cap.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (4) @(negedge clk);
    check("rst_cap.writes", 32'(wr_cnt - wr0), 32'd0);
    do_req("lw0c_after", 1'b0, F3_W, 32'h0C, 32'h0, 32'hCAFE_AB44, 1'b0, 3, 0, 32'h0, 32'h0);

    // req_valid held high; alternate LW targets after each accept.
    acc = 0;
    rsp0 = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k == 0) rsp0 = rsp_cnt;
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = F3_W;
      bus.req_addr = acc[0] ? 32'h14 : 32'h08;
      @(negedge clk);
      if (bus.req_ready) acc++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("hold.accepts", 32'(acc), 32'd3);
    check("hold.responses", 32'(rsp_cnt - rsp0), 32'd3);
    check("hold.queue_empty", 32'(rq.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store initiator between the RV32I execute stage and the word-only data memory.
- Accepts one LB/LH/LW/LBU/LHU/SB/SH/SW request at a time.
- Sign- or zero-extends load data.
- Performs read-modify-write for sub-word stores, because the memory has no byte enables.
- Flags misaligned, out-of-range and illegal accesses without touching memory.
- The memory is synchronous: reads are registered, a write suppresses the read, and the address is a word index.

Parameters:
MEM_WORDS, 32, number of implemented memory words; word index >= MEM_WORDS is out of range.
XLEN, 32, data/address width.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  combinational; 1 only in IDLE
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 of the load/store
req_addr  in  32  byte address
req_wdata  in  32  store data, low bytes used for SB/SH
rsp_valid  out  1  registered, one-cycle pulse per accepted request
rsp_rdata  out  32  registered, extended load data (0 for stores/errors)
rsp_err  out  1  registered, qualifies rsp_valid; misaligned/out-of-range/illegal
mem_address  out  32  word index = latched addr[31:2]
mem_data_in  out  32  write word to memory
mem_we  out  1  memory write enable
mem_data_out  in  32  memory read word, valid the cycle after a read is issued

Behaviour:
- States are IDLE, RD, CAP, WR and RESP. The state register and latched request are reset synchronously.
- Reset values:
  - state=IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Latched addr/wdata/funct3/we = 0, so mem_address=0, mem_data_in=0, mem_we=0.
- Memory outputs:
  - mem_* are combinational from state and latched registers.
  - mem_we=1 only in WR.
  - mem_address is driven from the latched word index in all states.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all request fields and classify:
    - err if funct3 is not legal for the direction (loads: 000, 001, 010, 100, 101; stores: 000, 001, 010).
    - err if halfword and addr[0]=1.
    - err if word and addr[1:0]!=0.
    - err if addr[31:2] >= MEM_WORDS.
  - err -> RESP. SW -> WR. Any load, SB or SH -> RD.
- RD: read issued (mem_we=0) -> CAP.
- CAP: mem_data_out is valid.
  - Load: extract the lane selected by addr[1:0], extend it, register into a result register -> RESP.
  - SB/SH: merge req_wdata[7:0] or [15:0] into the selected lane, hold the merged word -> WR.
- WR: mem_data_in = merged word (SW: wdata) -> RESP.
- RESP: rsp_valid=1 for exactly one cycle; rsp_rdata = result (0 if store or err); rsp_err per classification -> IDLE.
- Latency from the accept edge to the rsp_valid cycle:
  - LW/LB/LH/LBU/LHU: 3 cycles.
  - SW: 2 cycles.
  - SB/SH: 4 cycles.
  - Error: 1 cycle.
- No back-to-back acceptance: the next request can be accepted in the cycle after RESP.
- Lane rules:
  - byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH replicate the sign bit; LBU/LHU zero-fill.
- Reset asserted in any state:
  - Next edge -> IDLE, rsp_valid=0.
  - A pending WR is abandoned (no write after reset edge).
- req_valid outside IDLE is ignored; the request is not latched.

Decomposition:
- Shared package dmem_pkg holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - The state encoding (IDLE, RD, CAP, WR, RESP).
  - MEM_WORDS default.
- One natural combinational sub-module, dmem_lane_align, provides:
  - load extract/extend (word, funct3, offset -> 32-bit).
  - store merge (old word, wdata, funct3, offset -> new word).

Test Plan:
1. Memory word 5 preloaded 0x8070F0A5; LB addr 0x14 -> rsp_rdata 0xFFFFFFA5, err 0, rsp_valid exactly 3 cycles after accept; LBU addr 0x15 -> 0x000000F0; LH addr 0x16 -> 0xFFFF8070; LHU addr 0x16 -> 0x00008070.
2. SW addr 0x08 data 0xDEADBEEF -> mem_we one cycle with mem_address 2 and data 0xDEADBEEF, rsp 2 cycles after accept; then LW 0x08 -> 0xDEADBEEF.
3. Word 3 = 0x11223344; SB addr 0x0D wdata 0xAB -> single write of 0x1122AB44; SH addr 0x0E wdata 0xCAFE -> 0xCAFEAB44.
4. Errors, each giving rsp_err=1, rsp_rdata=0, mem_we never asserted, rsp 1 cycle after accept:
   - LW addr 0x02.
   - LH addr 0x01.
   - LW addr 0x80 (word 32).
   - store with funct3 100.
5. Reset raised in the cycle the FSM is in CAP of an SB -> no mem_we pulse, rsp_valid stays 0, req_ready=1 next cycle; target word unchanged.
6. req_valid held high for 10 cycles with alternating LW requests -> each accepted only when req_ready=1, one rsp_valid per accept, no lost or duplicate responses.
